// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus UART load port of the shared transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = uart_tx_pkg::UART_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_par_en;
  logic [NUM_REQ-1:0]        req_par_typ;
  logic [NUM_REQ-1:0]        req_ready;

  logic [DATA_W-1:0]         p_data;
  logic                      data_valid;
  logic                      par_en;
  logic                      par_typ;
  logic                      busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, req_par_en, req_par_typ, busy,
    output req_ready, p_data, data_valid, par_en, par_typ
  );

  // Requesters and UART side.
  modport slave (
    output req_valid, req_data, req_par_en, req_par_typ, busy,
    input  req_ready, p_data, data_valid, par_en, par_typ
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       found
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan leaves the lowest match; hi_* only considers indices >= ptr.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    found    = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources,
// with a start timeout on the UART busy handshake.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = UART_DATA_W,
  parameter int unsigned START_TO = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       start_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(START_TO + 1);

  arb_state_e         state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               accept_c;
  logic               timeout_c;
  logic [NUM_REQ-1:0] ready_c;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_par_en;
  logic               sel_par_typ;

  logic [DATA_W-1:0]  p_data_q;
  logic               data_valid_q;
  logic               par_en_q;
  logic               par_typ_q;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  assign ptr_n = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);

  // Next-state logic; timeout counter runs only while waiting for busy.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    accept_c  = 1'b0;
    timeout_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !bus.busy) begin
          accept_c = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT_START;
      end
      WAIT_START: begin
        if (bus.busy) begin
          state_n = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          timeout_c = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Winner's payload mux and one-hot accept.
  always_comb begin
    ready_c     = '0;
    sel_data    = '0;
    sel_par_en  = 1'b0;
    sel_par_typ = PAR_EVEN;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        ready_c[i]  = accept_c;
        sel_data    = bus.req_data[i*DATA_W +: DATA_W];
        sel_par_en  = bus.req_par_en[i];
        sel_par_typ = bus.req_par_typ[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Frame payload holds from ISSUE until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      grant_id     <= '0;
      data_valid_q <= 1'b0;
      start_err    <= 1'b0;
      arb_busy     <= 1'b0;
    end else begin
      data_valid_q <= accept_c;
      start_err    <= timeout_c;
      arb_busy     <= (state_n != IDLE);
      if (accept_c) begin
        ptr_q     <= ptr_n;
        p_data_q  <= sel_data;
        par_en_q  <= sel_par_en;
        par_typ_q <= sel_par_typ;
        grant_id  <= winner;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_en     = par_en_q;
  assign bus.par_typ    = par_typ_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed phases plus random traffic
// against a transaction-level model of grants, frame timing and timeouts.
module tb_uart_tx_arbiter;
  import uart_tx_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned TO   = 4;
  localparam int unsigned IW   = $clog2(N);
  localparam int          TO_I = int'(TO);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] grant_id;
  logic          arb_busy;
  logic          start_err;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .START_TO(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  int checks, errors, cyc;
  // Reference model state.
  int ptr_m, free_at, dv_at, err_at, busy_from, busy_to, acc_count;
  logic [DW-1:0] last_data;
  logic last_pen, last_ptyp, rst_prev;
  int last_id;
  int grant_log[$];
  // UART behaviour for the next accepted frame: delay 0 means busy never rises.
  int uart_delay, frame_len;
  // Requester payloads.
  logic [DW-1:0] v_data [N];
  logic v_pen [N];
  logic v_ptyp [N];
  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int gap_exp [3] = '{0, 1, 0};
  int acc0;
  logic [N-1:0] rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = v >> ((p + k) % N);
      if (s[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = 0; last_data = '0; last_pen = 1'b0; last_ptyp = 1'b0; last_id = 0;
    free_at = cyc; dv_at = -1; err_at = -1;
  endtask

  task automatic accept(input int w);
    last_data = v_data[w]; last_pen = v_pen[w]; last_ptyp = v_ptyp[w]; last_id = w;
    ptr_m = (w + 1) % N;
    dv_at = cyc + 1;
    acc_count++;
    grant_log.push_back(w);
    if (uart_delay > 0) begin
      busy_from = cyc + 1 + uart_delay;
      busy_to   = busy_from + frame_len - 1;
    end else begin
      busy_from = -1;
      busy_to   = -1;
    end
    if (uart_delay >= 1 && uart_delay <= TO_I) begin
      free_at = busy_to + 2;
      err_at  = -1;
    end else begin
      free_at = cyc + TO_I + 2;
      err_at  = free_at;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check req_ready.
  task automatic step(input logic [N-1:0] valid, input logic do_rst);
    logic [N-1:0] exp_ready;
    logic b;
    int w;
    @(negedge clk);
    cyc++;
    if (rst_prev) model_reset();
    chk("data_valid", 32'(bus.data_valid), 32'(cyc == dv_at));
    chk("start_err", 32'(start_err), 32'(cyc == err_at));
    chk("arb_busy", 32'(arb_busy), 32'(cyc < free_at));
    chk("p_data", 32'(bus.p_data), 32'(last_data));
    chk("par_en", 32'(bus.par_en), 32'(last_pen));
    chk("par_typ", 32'(bus.par_typ), 32'(last_ptyp));
    chk("grant_id", 32'(grant_id), 32'(last_id));
    b = (cyc >= busy_from) && (cyc <= busy_to);
    bus.busy = b;
    bus.req_valid = valid;
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW] = v_data[i];
      bus.req_par_en[i]  = v_pen[i];
      bus.req_par_typ[i] = v_ptyp[i];
    end
    rst = do_rst;
    #1;
    exp_ready = '0;
    w = -1;
    if (cyc >= free_at && !b && valid != '0) begin
      w = rr_pick(valid, ptr_m);
      exp_ready = N'(1) << w;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (w >= 0 && !do_rst) accept(w);
    rst_prev = do_rst;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_count = 0; rst_prev = 1'b1;
    busy_from = -1; busy_to = -1;
    uart_delay = 1; frame_len = 11;
    bus.busy = 1'b0; bus.req_valid = '0; bus.req_data = '0;
    bus.req_par_en = '0; bus.req_par_typ = '0;
    for (int i = 0; i < N; i++) begin
      v_data[i] = 8'($urandom); v_pen[i] = 1'b0; v_ptyp[i] = PAR_EVEN;
    end
    model_reset();

    step('0, 1'b1);
    step('0, 1'b1);

    // Single requester 2, held valid across two frames.
    v_data[2] = 8'h32; v_pen[2] = 1'b1; v_ptyp[2] = PAR_EVEN;
    repeat (16) step(4'b0100, 1'b0);
    repeat (4) step('0, 1'b0);

    // Strict rotation from a fresh pointer.
    step('0, 1'b1);
    grant_log.delete();
    repeat (80) step(4'b1111, 1'b0);
    chk("rr_count", 32'(grant_log.size() >= 5), 32'd1);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_seq", 32'(grant_log[k]), 32'(rr_exp[k]));

    // Rotation with idle requesters: move the pointer to 2, then only 0/1 ask.
    frame_len = 5;
    repeat (20) step('0, 1'b0);
    acc0 = acc_count;
    for (int k = 0; k < 40; k++) begin
      if (acc_count != acc0) break;
      step(4'b0010, 1'b0);
    end
    chk("gap_setup", 32'(acc_count != acc0), 32'd1);
    grant_log.delete();
    repeat (40) step(4'b0011, 1'b0);
    chk("gap_count", 32'(grant_log.size() >= 3), 32'd1);
    if (grant_log.size() >= 3)
      for (int k = 0; k < 3; k++) chk("gap_seq", 32'(grant_log[k]), 32'(gap_exp[k]));

    // Start timeout: dead UART, latest legal busy, one cycle too late.
    uart_delay = 0;        repeat (30) step(4'b1111, 1'b0);
    uart_delay = TO_I;     repeat (30) step(4'b1111, 1'b0);
    uart_delay = TO_I + 1; repeat (30) step(4'b1111, 1'b0);

    // Reset while the UART frame is in progress.
    uart_delay = 1; frame_len = 11;
    repeat (25) step('0, 1'b0);
    acc0 = acc_count;
    for (int k = 0; k < 40; k++) begin
      if (acc_count != acc0) break;
      step(4'b1000, 1'b0);
    end
    chk("mid_frame_accept", 32'(acc_count != acc0), 32'd1);
    repeat (4) step('0, 1'b0);
    step(4'b1111, 1'b1);
    repeat (25) step(4'b1111, 1'b0);

    // Parity passthrough per owner.
    frame_len = 6;
    v_pen[1] = 1'b1; v_ptyp[1] = PAR_ODD;
    v_pen[3] = 1'b0; v_ptyp[3] = PAR_EVEN;
    v_data[1] = 8'hA5; v_data[3] = 8'h5A;
    repeat (40) step(4'b1010, 1'b0);

    // Random traffic.
    rv = '0;
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 7) == 0) rv = N'($urandom);
      for (int i = 0; i < N; i++) begin
        v_data[i] = 8'($urandom); v_pen[i] = 1'($urandom); v_ptyp[i] = 1'($urandom);
      end
      case ($urandom_range(0, 9))
        0:       uart_delay = 0;
        1, 2:    uart_delay = int'($urandom_range(2, TO + 1));
        default: uart_delay = 1;
      endcase
      frame_len = int'($urandom_range(1, 12));
      step(rv, ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ independent byte sources using fair round-robin arbitration. It accepts a byte, with per-byte parity settings, from the granted requester over valid/ready. It presents the byte to the UART as a one-cycle data_valid pulse and tracks the UART busy flag until the frame completes. It sits between the system-side requesters and the UART's p_data/data_valid/par_en/par_typ/busy interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width, matches UART p_data
START_TO, 4, max cycles allowed after data_valid for UART busy to rise

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte
req_data  in  NUM_REQ*DATA_W  byte of requester i in slice [i*DATA_W +: DATA_W]
req_par_en  in  NUM_REQ  parity enable for requester i's byte
req_par_typ  in  NUM_REQ  parity type for requester i (0 even, 1 odd)
req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
p_data  out  DATA_W  byte to UART
data_valid  out  1  one-cycle load strobe to UART
par_en  out  1  parity enable to UART
par_typ  out  1  parity type to UART
busy  in  1  UART frame in progress
grant_id  out  clog2(NUM_REQ)  index of the requester owning the current frame
arb_busy  out  1  high in every state except IDLE
start_err  out  1  one-cycle pulse on START_TO expiry

Behaviour:
- Reset values: req_ready=0, p_data=0, data_valid=0, par_en=0, par_typ=0, grant_id=0, arb_busy=0, start_err=0, rr pointer=0, FSM=IDLE.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - If busy=0 and any req_valid, pick the first valid index at or after the rr pointer, wrapping modulo NUM_REQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - On the clock edge, latch data and parity bits into p_data/par_en/par_typ, set grant_id, set rr pointer = winner+1 (wrap to 0), go to ISSUE.
  - If busy=1 in IDLE, nothing is granted.
- ISSUE: data_valid=1 for exactly one cycle; next state WAIT_START; timeout counter cleared.
- WAIT_START:
  - busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When it reaches START_TO, pulse start_err for 1 cycle and return to IDLE; the byte is dropped, not retried.
- WAIT_DONE: stay while busy=1; busy=0 -> IDLE. A new grant is possible in the cycle IDLE is entered, giving a one-cycle gap minimum between frames.
- Latency: accept at edge N, data_valid high in cycle N+1, earliest next accept in IDLE after the busy falling edge.
- p_data/par_en/par_typ/grant_id hold stable from ISSUE until the next accept; they are not cleared on return to IDLE.
- req_ready is 0 in every state except IDLE, and at most one bit is ever set.
- Requester deasserting req_valid before acceptance is legal; no grant is recorded.
- The rr pointer advances only on an accept, never on a timeout without an accept.
- Simultaneous requests: strict rotation. With all NUM_REQ valid continuously, grants cycle 0,1,2,3,0,...
- Reset mid-frame: at the next edge with rst=1 all state returns to reset values, including data_valid dropping. The UART's own frame is not aborted by this block.

Decomposition:
- Package uart_tx_pkg: FSM state enum (IDLE/ISSUE/WAIT_START/WAIT_DONE), parity type constants PAR_EVEN=0 and PAR_ODD=1, DATA_W default.
- One sub-module rr_picker: combinational round-robin priority select. Inputs are the request vector and pointer; outputs are winner index and a found flag. It is reusable by other shared-resource arbiters.

Test Plan:
- Single requester: req_valid[2]=1, data 8'h32, par_en=1, par_typ=0 -> req_ready[2] for 1 cycle; next cycle data_valid=1, p_data=8'h32, par_en=1, par_typ=0, grant_id=2; no new grant until busy falls.
- Round robin: req_valid=4'b1111 held, behavioural UART busy for 11 cycles per frame -> grant_id sequence 0,1,2,3,0; each data_valid is a single-cycle pulse.
- Rotation with gaps: pointer at 2, req_valid=4'b0011 -> grant 0, then 1, then 0; requester 2/3 idle slots are skipped with no idle cycles.
- Start timeout: busy tied 0 after data_valid -> start_err pulses exactly START_TO+1 cycles after data_valid; FSM back in IDLE; the next requester is granted.
- Reset mid-frame: assert rst during WAIT_DONE with busy=1 -> next cycle arb_busy=0, req_ready=0, grant_id=0; no grant while busy remains 1.
- Parity passthrough: requester 1 with par_typ=1, par_en=1 and requester 3 with par_en=0 -> par_en/par_typ at the UART match each owner during its own data_valid cycle.
